// File: rtl/exc_ov_ctrl.sv
// rtl/exc_ov_ctrl.sv - trap controller: overflow/ecall/irq traps, mret, machine CSRs, next-PC select
module exc_ov_ctrl #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0008,
    parameter int          SYNC_STG  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ov,
    input  logic        ov_en,
    input  logic        ecall,
    input  logic        mret,
    input  logic        intr,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        trap,
    output logic        wb_kill,
    output logic [1:0]  pc_sel,
    output logic [31:0] trap_pc,
    output logic        inta
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;

    logic [SYNC_STG-1:0] sync;
    logic                intr_s;
    logic                mie, mpie;
    logic [31:0]         mtvec, mepc, mcause;
    logic                exc_ov, exc_ec, irq, do_mret, csr_wr;
    logic [31:0]         cause;

    assign intr_s = sync[SYNC_STG-1];

    // Events are gated by rst so nothing leaks out while reset is held.
    assign exc_ov  = ov & ov_en & ~rst;
    assign exc_ec  = ecall & ~rst;
    assign irq     = intr_s & mie & ~inta & ~rst;
    assign trap    = exc_ov | exc_ec | irq;
    assign wb_kill = trap;
    assign do_mret = mret & ~trap & ~rst;
    // The trapping instruction is killed, so its CSR write is dropped as well.
    assign csr_wr  = csr_we & ~trap & ~rst;

    always_comb begin
        cause = 32'h8000_000B;
        if (exc_ov)
            cause = 32'h0000_0018;
        else if (exc_ec)
            cause = 32'd11;
    end

    always_comb begin
        pc_sel  = 2'd0;
        trap_pc = mepc;
        if (trap) begin
            pc_sel  = 2'd1;
            trap_pc = mtvec;
        end else if (do_mret) begin
            pc_sel  = 2'd2;
        end
    end

    always_comb begin
        case (csr_addr)
            A_MSTATUS: csr_rdata = {24'd0, mpie, 3'd0, mie, 3'd0};
            A_MTVEC:   csr_rdata = mtvec;
            A_MEPC:    csr_rdata = mepc;
            A_MCAUSE:  csr_rdata = mcause;
            default:   csr_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            mie    <= 1'b0;
            mpie   <= 1'b0;
            mtvec  <= {MTVEC_RST[31:2], 2'b00};
            mepc   <= 32'd0;
            mcause <= 32'd0;
            inta   <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STG-2:0], intr};
            // Acknowledge only when the interrupt itself was the cause taken.
            inta <= irq & ~exc_ov & ~exc_ec;
            if (trap) begin
                mepc   <= pc;
                mcause <= cause;
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (do_mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end else if (csr_wr) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        mie  <= csr_wdata[3];
                        mpie <= csr_wdata[7];
                    end
                    A_MTVEC:   mtvec  <= {csr_wdata[31:2], 2'b00};
                    A_MEPC:    mepc   <= {csr_wdata[31:2], 2'b00};
                    A_MCAUSE:  mcause <= csr_wdata;
                    default:   ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exc_ov_ctrl.sv
// tb/tb_exc_ov_ctrl.sv - directed self-checking bench for exc_ov_ctrl
module tb_exc_ov_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        ov, ov_en, ecall, mret, intr, csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata, csr_rdata, trap_pc;
    logic        trap, wb_kill, inta;
    logic [1:0]  pc_sel;

    int vectors = 0;
    int miscompares = 0;

    exc_ov_ctrl #(.MTVEC_RST(32'h0000_0008), .SYNC_STG(2)) dut (
        .clk(clk), .rst(rst), .pc(pc), .ov(ov), .ov_en(ov_en), .ecall(ecall),
        .mret(mret), .intr(intr), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .trap(trap), .wb_kill(wb_kill),
        .pc_sel(pc_sel), .trap_pc(trap_pc), .inta(inta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; pc = 32'd0; ov = 0; ov_en = 0; ecall = 0; mret = 0; intr = 0;
        csr_we = 0; csr_addr = 12'h300; csr_wdata = 32'd0;
        #12;
        // reset state
        rd("rst_mtvec", 12'h305, 32'h8);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mcause", 12'h342, 32'h0);
        rd("unknown_csr", 12'h123, 32'h0);
        ecall = 1; #1;
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_pc_sel", {30'd0, pc_sel}, 32'd0);
        chk("rst_inta", {31'd0, inta}, 32'd0);
        ecall = 0;
        @(negedge clk); rst = 1'b0;
        tick();

        // overflow trap
        pc = 32'h40; ov = 1; ov_en = 1; #1;
        chk("ov_trap", {31'd0, trap}, 32'd1);
        chk("ov_wb_kill", {31'd0, wb_kill}, 32'd1);
        chk("ov_pc_sel", {30'd0, pc_sel}, 32'd1);
        chk("ov_trap_pc", trap_pc, 32'h8);
        tick();
        ov = 0; ov_en = 0;
        rd("ov_mepc", 12'h341, 32'h40);
        rd("ov_mcause", 12'h342, 32'h18);
        ov = 1; pc = 32'h44; #1;
        chk("ov_no_en", {31'd0, trap}, 32'd0);
        chk("ov_no_en_sel", {30'd0, pc_sel}, 32'd0);
        ov = 0;

        // mtvec write with low bits forced, then ecall
        csr_we = 1; csr_addr = 12'h305; csr_wdata = 32'h0000_1237;
        tick();
        csr_we = 0;
        rd("mtvec_wr", 12'h305, 32'h1234);
        ecall = 1; pc = 32'h60; #1;
        chk("ec_trap_pc", trap_pc, 32'h1234);
        tick();
        ecall = 0;
        rd("ec_mcause", 12'h342, 32'd11);
        rd("ec_mepc", 12'h341, 32'h60);

        // interrupt through synchroniser
        csr_we = 1; csr_addr = 12'h300; csr_wdata = 32'h8;
        tick();
        csr_we = 0;
        rd("mstatus_wr", 12'h300, 32'h8);
        intr = 1; pc = 32'h80;
        tick();
        chk("irq_c1_trap", {31'd0, trap}, 32'd0);
        tick();
        chk("irq_c2_trap", {31'd0, trap}, 32'd1);
        chk("irq_c2_inta", {31'd0, inta}, 32'd0);
        tick();
        chk("irq_c3_inta", {31'd0, inta}, 32'd1);
        chk("irq_c3_trap", {31'd0, trap}, 32'd0);
        rd("irq_mcause", 12'h342, 32'h8000_000B);
        rd("irq_mstatus", 12'h300, 32'h80);
        rd("irq_mepc", 12'h341, 32'h80);
        tick();
        chk("irq_c4_inta", {31'd0, inta}, 32'd0);
        chk("irq_c4_trap", {31'd0, trap}, 32'd0);
        tick();
        chk("irq_c5_trap", {31'd0, trap}, 32'd0);
        intr = 0;
        tick(); tick();

        // mret
        csr_we = 1; csr_addr = 12'h341; csr_wdata = 32'h103;
        tick();
        csr_we = 0;
        rd("mepc_wr", 12'h341, 32'h100);
        mret = 1; #1;
        chk("mret_pc_sel", {30'd0, pc_sel}, 32'd2);
        chk("mret_trap_pc", trap_pc, 32'h100);
        chk("mret_trap", {31'd0, trap}, 32'd0);
        tick();
        mret = 0;
        rd("mret_mstatus", 12'h300, 32'h88);

        // overflow and irq in the same cycle
        intr = 1;
        tick(); tick();
        pc = 32'h200; ov = 1; ov_en = 1; #1;
        chk("both_trap", {31'd0, trap}, 32'd1);
        tick();
        ov = 0; ov_en = 0;
        rd("both_mcause", 12'h342, 32'h18);
        rd("both_mstatus", 12'h300, 32'h80);
        chk("both_inta", {31'd0, inta}, 32'd0);
        chk("pend_masked", {31'd0, trap}, 32'd0);
        pc = 32'h300; mret = 1; #1;
        chk("both_mret_pc", trap_pc, 32'h200);
        chk("both_mret_sel", {30'd0, pc_sel}, 32'd2);
        tick();
        mret = 0; pc = 32'h204; #1;
        chk("pend_trap", {31'd0, trap}, 32'd1);
        chk("pend_sel", {30'd0, pc_sel}, 32'd1);
        tick();
        rd("pend_mcause", 12'h342, 32'h8000_000B);
        rd("pend_mepc", 12'h341, 32'h204);
        chk("pend_inta", {31'd0, inta}, 32'd1);

        // async reset during inta cycle
        rst = 1; #1;
        chk("arst_inta", {31'd0, inta}, 32'd0);
        rd("arst_mepc", 12'h341, 32'h0);
        rd("arst_mcause", 12'h342, 32'h0);
        rd("arst_mtvec", 12'h305, 32'h8);
        chk("arst_pc_sel", {30'd0, pc_sel}, 32'd0);
        intr = 0;
        @(negedge clk); rst = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
